frame_write_queue: RTL

- Parametrised buffered writer from the rasteriser into the frame buffer; successor to the fixed two-channel (colour + Z) single-beat write queue.
- Each entry carries one word per channel (colour, Z, optionally stencil/aux) plus a per-pixel active mask.
- Entries drain to NUM_CHANNELS independent memory write masters. Each entry retires once every channel has accepted its write. Throughput is one entry per clock with no bubble between entries.

---
 rtl/frame_write_pkg.sv | 31 +++
 rtl/frame_write_queue_fifo.sv | 61 ++++++
 rtl/frame_write_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/frame_write_pkg.sv
// Shared constants and helpers for the frame buffer write queue.
package frame_write_pkg;

  localparam logic [7:0] BURST_SINGLE = 8'h01;
  localparam int SKIP_ADDRESS = 0;

  // Upper bounds for the byte-enable helper; callers cast the result to their width.
  localparam int MAX_PIXELS     = 32;
  localparam int MAX_BYTE_LANES = 256;
  localparam int PIX_IDX_W      = $clog2(MAX_PIXELS);

  function automatic int entry_width(input int num_channels, input int addr_width,
                                     input int data_width, input int pixels_per_word);
    return num_channels * (addr_width + data_width) + pixels_per_word;
  endfunction

  function automatic logic [MAX_BYTE_LANES-1:0] byte_enable_expand(
      input logic [MAX_PIXELS-1:0] pixel_active,
      input int bytes_per_pixel,
      input int pixels_per_word);
    logic [MAX_BYTE_LANES-1:0] be;
    be = '0;
    for (int i = 0; i < MAX_BYTE_LANES; i++) begin
      if (i < pixels_per_word * bytes_per_pixel) begin
        be[i] = pixel_active[PIX_IDX_W'(i / bytes_per_pixel)];
      end
    end
    return be;
  endfunction

endpackage

// File: rtl/frame_write_queue_fifo.sv
// Show-ahead FIFO: the head entry is readable combinationally whenever not empty.
module sync_show_ahead_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push at full is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/frame_write_queue.sv
// Buffered rasteriser-to-frame-buffer writer: one FIFO entry fans out to
// NUM_CHANNELS single-beat write masters and retires when all have accepted.
module frame_write_queue
  import frame_write_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int ADDR_WIDTH      = 29,
  parameter int DATA_WIDTH      = 64,
  parameter int PIXELS_PER_WORD = 2,
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 enqueue,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   addr_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_in,
  input  logic [PIXELS_PER_WORD-1:0]           pixel_active,
  output logic [FIFO_DEPTH_LOG2:0]             size,
  output logic                                 full,
  output logic                                 idle,
  output logic                                 overflow,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   wr_address,
  output logic [NUM_CHANNELS*8-1:0]            wr_burstcount,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   wr_writedata,
  output logic [NUM_CHANNELS*DATA_WIDTH/8-1:0] wr_byteenable,
  output logic [NUM_CHANNELS-1:0]              wr_write,
  input  logic [NUM_CHANNELS-1:0]              wr_waitrequest
);

  localparam int BPP     = DATA_WIDTH / 8 / PIXELS_PER_WORD;
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int AV_W    = NUM_CHANNELS * ADDR_WIDTH;
  localparam int DV_W    = NUM_CHANNELS * DATA_WIDTH;
  localparam int ENTRY_W = entry_width(NUM_CHANNELS, ADDR_WIDTH, DATA_WIDTH, PIXELS_PER_WORD);

  logic [ENTRY_W-1:0]         fifo_din, fifo_dout;
  logic                       fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;

  logic [AV_W-1:0]            head_addr;
  logic [DV_W-1:0]            head_data;
  logic [PIXELS_PER_WORD-1:0] head_active;
  logic [NUM_CHANNELS-1:0]    head_pending, chan_done;
  logic                       all_done, load;

  logic [NUM_CHANNELS-1:0]    pending_q, pending_d;
  logic [AV_W-1:0]            addr_q, addr_d;
  logic [DV_W-1:0]            data_q, data_d;
  logic [BE_W-1:0]            be_q, be_d;
  logic                       overflow_q, overflow_d;

  assign fifo_din = {pixel_active, data_in, addr_in};
  assign {head_active, head_data, head_addr} = fifo_dout;

  sync_show_ahead_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (enqueue),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    assign head_pending[gi] = (head_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(SKIP_ADDRESS))
                              && (|head_active);
    assign chan_done[gi]    = !pending_q[gi] || !wr_waitrequest[gi];
    assign wr_byteenable[gi*BE_W +: BE_W] = be_q;
    assign wr_burstcount[gi*8 +: 8]       = BURST_SINGLE;
  end

  assign all_done = &chan_done;
  assign load     = all_done && !fifo_empty;
  assign fifo_pop = load;

  always_comb begin
    pending_d  = pending_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    // An enqueue at full is lost unless the head retires in the same cycle.
    overflow_d = overflow_q | (enqueue && fifo_full && !fifo_pop);
    if (load) begin
      pending_d = head_pending;
      addr_d    = head_addr;
      data_d    = head_data;
      be_d      = BE_W'(byte_enable_expand(MAX_PIXELS'(head_active), BPP, PIXELS_PER_WORD));
    end else if (all_done) begin
      pending_d = '0;
    end else begin
      pending_d = pending_q & wr_waitrequest;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_write     = pending_q;
  assign wr_address   = addr_q;
  assign wr_writedata = data_q;
  assign size         = fifo_count;
  assign full         = fifo_full;
  assign overflow     = overflow_q;
  assign idle         = (fifo_count == '0) && (pending_q == '0);

endmodule
